mdu_div: RTL
============

Name: mdu_div

Overview:
- Iterative 32-bit integer divider for the EX stage; sits beside the single-cycle ALU.
- Serves the LoongArch DIV.W, MOD.W, DIV.WU and MOD.WU instructions, which the ALU does not implement.
- Uses the same operand convention as the ALU (a, b) and a one-hot operation select.
- Valid/ready handshake on both sides, so the pipeline can stall while it iterates.

Parameters:
- WIDTH, 32, operand and result width in bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rstn  in  1  reset, asynchronous assert, active-low.
- flush  in  1  synchronous pipeline flush; aborts any operation in progress.
- in_valid  in  1  a, b and op are valid this cycle.
- in_ready  out  1  divider can accept a new operation.
- a  in  WIDTH  dividend.
- b  in  WIDTH  divisor.
- op  in  4  one-hot select: bit0 DIV (signed quotient), bit1 MOD (signed remainder), bit2 DIVU, bit3 MODU.
- out_valid  out  1  y holds the final result.
- out_ready  in  1  consumer takes y this cycle.
- y  out  WIDTH  result, either quotient or remainder as selected by op.

Behaviour:
- Reset (rstn low, asynchronous): state IDLE, in_ready=1, out_valid=0, y=0, counter=0, all internal registers 0.
- States:
  - IDLE: in_ready=1. Accept when in_valid && !flush.
    - If b==0, go to DONE directly.
    - Otherwise go to CALC with counter=0.
  - CALC: in_ready=0. One restoring step per cycle.
    - Shift {rem,quo} left by 1.
    - Trial-subtract |b| from rem. If the result is non-negative, keep it and set the quo LSB to 1.
    - Counter increments each step. After step WIDTH-1, go to FIX.
  - FIX: one cycle. Apply the sign correction, select quotient or remainder, register the result into y. Go to DONE.
  - DONE: out_valid=1, y stable. When out_ready=1, return to IDLE; the next accept is no earlier than the following cycle.
- Accept-on-IDLE registers the operands and op flags:
  - |a| and |b|. Signed ops take the two's-complement magnitude; unsigned ops take the raw value.
  - sign_q = a[31]^b[31] (signed ops only).
  - sign_r = a[31] (signed ops only).
  - Op flags from op. If op is not one-hot, priority is DIV > MOD > DIVU > MODU. If op==0, the request is ignored: not accepted, stay in IDLE.
- Latency (b!=0):
  - Accept edge = cycle 0.
  - 32 CALC cycles, then FIX.
  - out_valid high from cycle 34 until the handshake completes.
- Latency (b==0): out_valid high at cycle 1.
- Sign rules:
  - Quotient truncates toward zero and is negated when sign_q=1.
  - Remainder takes the dividend's sign: negated when sign_r=1.
  - Required identity when b!=0: a == q*b + r.
- Divide by zero (all four ops):
  - Quotient = 32'hFFFF_FFFF.
  - Remainder = a, unmodified.
- Signed overflow: a=32'h8000_0000, b=32'hFFFF_FFFF gives DIV=32'h8000_0000 and MOD=0. The magnitude path produces this naturally; no special case is required, but the bench must check it.
- Flush:
  - flush=1 in any state: next state IDLE, out_valid drops next cycle, and the result is discarded.
  - flush and in_valid in the same cycle: flush wins, the request is not accepted.
  - flush in DONE with out_ready=1 in the same cycle: the handshake is void and the consumer must ignore y.
- Backpressure: in DONE with out_ready=0, y and out_valid hold indefinitely and no new request is accepted.
- Reset mid-operation: immediate return to the reset state; nothing is retained.

Decomposition:
- Package mdu_pkg holds:
  - op bit indices OP_DIV=0, OP_MOD=1, OP_DIVU=2, OP_MODU=3;
  - state enum {S_IDLE, S_CALC, S_FIX, S_DONE};
  - constant DIV0_Q = 32'hFFFF_FFFF.
- One natural sub-module: div_step.
  - Combinational single restoring step.
  - Inputs rem, quo, divisor. Outputs next rem, next quo.
  - Instantiated once inside the FSM datapath.

Test Plan:
- DIVU a=100, b=7 -> y=14 with out_valid first high 34 cycles after accept; MODU on the same operands -> y=2.
- DIV a=-7 (32'hFFFF_FFF9), b=2 -> y=32'hFFFF_FFFD (-3); MOD on the same operands -> y=32'hFFFF_FFFF (-1); MOD a=7, b=-2 -> y=1.
- DIV a=32'h8000_0000, b=32'hFFFF_FFFF -> y=32'h8000_0000; MOD on the same operands -> y=0.
- DIVU a=123, b=0 -> y=32'hFFFF_FFFF one cycle after accept; MOD a=-5, b=0 -> y=32'hFFFF_FFFB.
- Backpressure and flush:
  - Hold out_ready=0 for 10 cycles in DONE -> y stable and in_ready=0 throughout.
  - Assert flush at CALC cycle 15 -> IDLE next cycle, out_valid never rises, and the next DIVU 9/3 returns 3.
- Reset mid-CALC (rstn low for 1 cycle) -> in_ready=1 and out_valid=0 immediately; random signed/unsigned regression of 10k ops checked against a reference model, including the a==q*b+r identity.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative divider: op-select bit positions,
// FSM state encoding and the divide-by-zero quotient constant.
package mdu_pkg;

    localparam int OP_DIV  = 0;
    localparam int OP_MOD  = 1;
    localparam int OP_DIVU = 2;
    localparam int OP_MODU = 3;

    localparam logic [31:0] DIV0_Q = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_e;

endpackage

// File: rtl/mdu_div_step.sv
// One combinational restoring-division step: shift {rem,quo} left by one,
// trial-subtract the divisor, keep the difference when it is non-negative.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_quo,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem,
    output logic [WIDTH-1:0] o_quo
);

    logic [WIDTH:0] w_shift_rem;
    logic [WIDTH:0] w_trial;

    // One extra bit: the shifted remainder can reach 2*divisor-1, and the
    // top bit of the difference is then the borrow.
    assign w_shift_rem = {i_rem, i_quo[WIDTH-1]};
    assign w_trial     = w_shift_rem - {1'b0, i_divisor};

    always_comb begin
        if (!w_trial[WIDTH]) begin
            o_rem = w_trial[WIDTH-1:0];
            o_quo = {i_quo[WIDTH-2:0], 1'b1};
        end else begin
            o_rem = w_shift_rem[WIDTH-1:0];
            o_quo = {i_quo[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/mdu_div.sv
// Iterative 32-step restoring divider for DIV.W/MOD.W/DIV.WU/MOD.WU with
// valid/ready handshakes on both sides and a synchronous pipeline flush.
module mdu_div
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y
);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] r_y;
    logic             r_sign_q;
    logic             r_sign_r;
    logic             r_want_rem;

    logic             w_signed;
    logic             w_want_rem;
    logic             w_accept;
    logic             w_b_zero;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_quo_nxt;
    logic [WIDTH-1:0] w_q_fixed;
    logic [WIDTH-1:0] w_r_fixed;
    logic [WIDTH-1:0] w_result;

    // Non-one-hot selects resolve DIV > MOD > DIVU > MODU.
    assign w_signed   = op[OP_DIV] | op[OP_MOD];
    assign w_want_rem = !op[OP_DIV] && (op[OP_MOD] || (!op[OP_DIVU] && op[OP_MODU]));
    assign w_b_zero   = (b == '0);
    assign w_accept   = (r_state == S_IDLE) && in_valid && !flush && (op != 4'b0000);

    assign w_abs_a = (w_signed && a[WIDTH-1]) ? -a : a;
    assign w_abs_b = (w_signed && b[WIDTH-1]) ? -b : b;

    div_step #(.WIDTH(WIDTH)) u_step (
        .i_rem     (r_rem),
        .i_quo     (r_quo),
        .i_divisor (r_div),
        .o_rem     (w_rem_nxt),
        .o_quo     (w_quo_nxt)
    );

    assign w_q_fixed = r_sign_q ? -r_quo : r_quo;
    assign w_r_fixed = r_sign_r ? -r_rem : r_rem;
    assign w_result  = r_want_rem ? w_r_fixed : w_q_fixed;

    // NOTE: every output of this block gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (w_accept) w_state_nxt = w_b_zero ? S_DONE : S_CALC;
            end
            S_CALC: begin
                if (r_cnt == CNT_W'(WIDTH - 1)) w_state_nxt = S_FIX;
            end
            S_FIX: begin
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (flush) w_state_nxt = S_IDLE;
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt      <= '0;
            r_rem      <= '0;
            r_quo      <= '0;
            r_div      <= '0;
            r_y        <= '0;
            r_sign_q   <= 1'b0;
            r_sign_r   <= 1'b0;
            r_want_rem <= 1'b0;
        end else if (w_accept) begin
            r_cnt      <= '0;
            r_rem      <= '0;
            r_quo      <= w_abs_a;
            r_div      <= w_abs_b;
            r_sign_q   <= w_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            r_sign_r   <= w_signed & a[WIDTH-1];
            r_want_rem <= w_want_rem;
            // Divide by zero skips the iteration; the result is known now.
            if (w_b_zero) r_y <= w_want_rem ? a : WIDTH'(DIV0_Q);
        end else if (r_state == S_CALC) begin
            r_rem <= w_rem_nxt;
            r_quo <= w_quo_nxt;
            r_cnt <= r_cnt + 1'b1;
        end else if (r_state == S_FIX && !flush) begin
            r_y <= w_result;
        end
    end

    assign y = r_y;

endmodule
